// File: rtl/z_1_rtc_pkg.sv
// Shared RTC definitions: scheduler FSM states,
// default widths and the one-shot period code.
package z_1_rtc_pkg;

    localparam int TIME_W_DEF   = 64;
    localparam int PERIOD_W_DEF = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_SCAN = 2'd2;

    localparam int unsigned PERIOD_ONESHOT = 0;

endpackage

// File: rtl/alarm_slot.sv
// One alarm slot: target, reload period and armed flag.
// A fire strobe reloads a periodic slot or disarms a one-shot.
module alarm_slot
    import z_1_rtc_pkg::*;
#(
    parameter int TIME_W   = TIME_W_DEF,
    parameter int PERIOD_W = PERIOD_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [TIME_W-1:0]   wr_target,
    input  logic [PERIOD_W-1:0] wr_period,
    input  logic                wr_arm,
    input  logic                fire,
    output logic [TIME_W-1:0]   target,
    output logic [PERIOD_W-1:0] period,
    output logic                armed
);

    logic oneshot;

    assign oneshot = (period == PERIOD_W'(PERIOD_ONESHOT));

    // Slot state: writes win over a same-cycle fire.
    always_ff @(posedge clk) begin
        if (rst) begin
            target <= '0;
            period <= '0;
            armed  <= 1'b0;
        end else if (wr_en) begin
            target <= wr_target;
            period <= wr_period;
            armed  <= wr_arm;
        end else if (fire) begin
            if (oneshot)
                armed <= 1'b0;
            else
                target <= target + TIME_W'(period);
        end
    end

endmodule

// File: rtl/alarm_scheduler.sv
// Multi-slot alarm scheduler with one time-shared comparator.
// Define ALARM_CATCHUP_EN to fire past-due alarms (>= match).
module alarm_scheduler
    import z_1_rtc_pkg::*;
#(
    parameter int NUM_ALARMS = 4,
    parameter int SLOT_W     = 2,
    parameter int TIME_W     = TIME_W_DEF,
    parameter int PERIOD_W   = PERIOD_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  one_hz,
    input  logic [TIME_W-1:0]     epoch_time,
    input  logic                  wr_en,
    input  logic [SLOT_W-1:0]     wr_slot,
    input  logic [TIME_W-1:0]     wr_target,
    input  logic [PERIOD_W-1:0]   wr_period,
    input  logic                  wr_arm,
    input  logic                  clr_en,
    input  logic [NUM_ALARMS-1:0] clr_mask,
    input  logic [NUM_ALARMS-1:0] irq_mask,
    output logic [NUM_ALARMS-1:0] pending,
    output logic [NUM_ALARMS-1:0] armed,
    output logic                  busy,
    output logic                  irq
);

    state_t              state;
    logic [SLOT_W-1:0]   idx;
    logic                tick_lat;
    logic                last_slot;
    logic                time_hit;
    logic                scan_hit;
    logic [TIME_W-1:0]   cur_target;
    logic [NUM_ALARMS-1:0] fire;

    logic [TIME_W-1:0]   slot_target [NUM_ALARMS];
    logic [PERIOD_W-1:0] slot_period [NUM_ALARMS];

    for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_slot
        alarm_slot #(
            .TIME_W  (TIME_W),
            .PERIOD_W(PERIOD_W)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (wr_en && (wr_slot == SLOT_W'(i))),
            .wr_target(wr_target),
            .wr_period(wr_period),
            .wr_arm   (wr_arm),
            .fire     (fire[i]),
            .target   (slot_target[i]),
            .period   (slot_period[i]),
            .armed    (armed[i])
        );
    end

    assign cur_target = slot_target[idx];
    assign last_slot  = (idx == SLOT_W'(NUM_ALARMS - 1));

`ifdef ALARM_CATCHUP_EN
    assign time_hit = (epoch_time >= cur_target);
`else
    assign time_hit = (epoch_time == cur_target);
`endif

    assign scan_hit = (state == ST_SCAN) && armed[idx] && time_hit;

    // Route the hit to the scanned slot unless a write overrides it.
    always_comb begin
        fire = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            fire[i] = scan_hit && (idx == SLOT_W'(i))
                    && !(wr_en && (wr_slot == SLOT_W'(i)));
        end
    end

    // Scan FSM: IDLE -> WAIT -> SCAN over all slots, rescan on latched tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            tick_lat <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (one_hz)
                        state <= ST_WAIT;
                end
                ST_WAIT: begin
                    state <= ST_SCAN;
                    idx   <= '0;
                    if (one_hz)
                        tick_lat <= 1'b1;
                end
                ST_SCAN: begin
                    if (last_slot) begin
                        idx <= '0;
                        if (tick_lat || one_hz) begin
                            state    <= ST_WAIT;
                            tick_lat <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        idx <= idx + 1'b1;
                        if (one_hz)
                            tick_lat <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Pending flags: a new match outranks a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst)
            pending <= '0;
        else
            pending <= (pending & ~(clr_en ? clr_mask : '0)) | fire;
    end

    assign busy = (state != ST_IDLE);
    assign irq  = |(pending & irq_mask);

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed bench for alarm_scheduler.
// Builds with or without ALARM_CATCHUP_EN.
module tb_alarm_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        one_hz;
    logic [63:0] epoch_time;
    logic        wr_en;
    logic [1:0]  wr_slot;
    logic [63:0] wr_target;
    logic [31:0] wr_period;
    logic        wr_arm;
    logic        clr_en;
    logic [3:0]  clr_mask;
    logic [3:0]  irq_mask;
    logic [3:0]  pending;
    logic [3:0]  armed;
    logic        busy;
    logic        irq;

    int checks = 0;
    int errors = 0;

    alarm_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .one_hz    (one_hz),
        .epoch_time(epoch_time),
        .wr_en     (wr_en),
        .wr_slot   (wr_slot),
        .wr_target (wr_target),
        .wr_period (wr_period),
        .wr_arm    (wr_arm),
        .clr_en    (clr_en),
        .clr_mask  (clr_mask),
        .irq_mask  (irq_mask),
        .pending   (pending),
        .armed     (armed),
        .busy      (busy),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] s, input logic [63:0] t,
                      input logic [31:0] p, input logic a);
        @(negedge clk);
        wr_en = 1'b1; wr_slot = s; wr_target = t;
        wr_period = p; wr_arm = a;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic clr(input logic [3:0] m);
        @(negedge clk);
        clr_en = 1'b1; clr_mask = m;
        @(negedge clk);
        clr_en = 1'b0; clr_mask = '0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {63'd0, busy}, 64'd0);
    endtask

    task automatic tick(input logic [63:0] e);
        @(negedge clk);
        epoch_time = e; one_hz = 1'b1;
        @(negedge clk);
        one_hz = 1'b0;
        wait_idle("tick_done");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; one_hz = 1'b0; epoch_time = '0;
        wr_en = 1'b0; wr_slot = '0; wr_target = '0;
        wr_period = '0; wr_arm = 1'b0;
        clr_en = 1'b0; clr_mask = '0; irq_mask = '0;
        repeat (3) @(negedge clk);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_armed", 64'(armed), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        chk("rst_target", dut.slot_target[2], 64'd0);
        rst = 1'b0;

        // one-shot on slot 0 with exact timing
        wr(2'd0, 64'd100, 32'd0, 1'b1);
        chk("os_armed", 64'(armed), 64'h1);
        @(negedge clk);
        epoch_time = 64'd100; one_hz = 1'b1;
        @(negedge clk);
        one_hz = 1'b0;
        chk("os_busy_t1", 64'(busy), 64'd1);
        chk("os_pend_t1", 64'(pending), 64'd0);
        @(negedge clk);
        chk("os_pend_t2", 64'(pending), 64'd0);
        @(negedge clk);
        chk("os_pend_t3", 64'(pending), 64'h1);
        chk("os_disarm", 64'(armed), 64'd0);
        chk("os_irq_masked", 64'(irq), 64'd0);
        irq_mask = 4'h1;
        #1;
        chk("os_irq", 64'(irq), 64'd1);
        wait_idle("os_idle");
        clr(4'h1);
        chk("os_clr", 64'(pending), 64'd0);

        // periodic slot 2
        wr(2'd2, 64'd10, 32'd5, 1'b1);
        tick(64'd10);
        chk("per_10", 64'(pending), 64'h4);
        clr(4'h4);
        tick(64'd15);
        chk("per_15", 64'(pending), 64'h4);
        clr(4'h4);
        tick(64'd20);
        chk("per_20", 64'(pending), 64'h4);
        clr(4'h4);
        chk("per_target", dut.slot_target[2], 64'd25);
        chk("per_armed", 64'(armed), 64'h4);

        // wrap on slot 1
        wr(2'd1, 64'hFFFF_FFFF_FFFF_FFFE, 32'd4, 1'b1);
        tick(64'hFFFF_FFFF_FFFF_FFFE);
        chk("wrap_pend", 64'(pending), 64'h2);
        chk("wrap_target", dut.slot_target[1], 64'd2);
        clr(4'h2);

        // write during compare of slot 1; clear during set of slot 3
        wr(2'd3, 64'd2, 32'd0, 1'b1);
        @(negedge clk);
        epoch_time = 64'd2; one_hz = 1'b1;
        @(negedge clk);
        one_hz = 1'b0;
        @(negedge clk);
        @(negedge clk);
        wr_en = 1'b1; wr_slot = 2'd1; wr_target = 64'd500;
        wr_period = 32'd0; wr_arm = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        clr_en = 1'b1; clr_mask = 4'h8;
        @(negedge clk);
        clr_en = 1'b0; clr_mask = '0;
        chk("sim_pend", 64'(pending), 64'h8);
        chk("sim_target", dut.slot_target[1], 64'd500);
        chk("sim_armed", 64'(armed), 64'h6);
        wait_idle("sim_idle");
        clr(4'h8);

        // back-to-back ticks
        wr(2'd0, 64'd700, 32'd1, 1'b1);
        wr(2'd2, 64'd701, 32'd0, 1'b1);
        @(negedge clk);
        epoch_time = 64'd700; one_hz = 1'b1;
        @(negedge clk);
        one_hz = 1'b0;
        @(negedge clk);
        @(negedge clk);
        one_hz = 1'b1;
        @(negedge clk);
        one_hz = 1'b0;
        chk("b2b_first", 64'(pending), 64'h1);
        @(negedge clk);
        @(negedge clk);
        chk("b2b_wait", 64'(busy), 64'd1);
        epoch_time = 64'd701;
        wait_idle("b2b_idle");
        chk("b2b_pend", 64'(pending), 64'h5);
        chk("b2b_target", dut.slot_target[0], 64'd702);
        chk("b2b_armed", 64'(armed), 64'h3);

        // reset mid-scan with a latched tick
        irq_mask = 4'hF;
        #1;
        chk("pre_rst_irq", 64'(irq), 64'd1);
        @(negedge clk);
        epoch_time = 64'd9999; one_hz = 1'b1;
        @(negedge clk);
        one_hz = 1'b0;
        @(negedge clk);
        one_hz = 1'b1;
        @(negedge clk);
        one_hz = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("mrst_pending", 64'(pending), 64'd0);
        chk("mrst_armed", 64'(armed), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_irq", 64'(irq), 64'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("mrst_no_scan", 64'(busy), 64'd0);

        // past-due alarm
        wr(2'd0, 64'd50, 32'd0, 1'b1);
        tick(64'd60);
`ifdef ALARM_CATCHUP_EN
        chk("late_pend", 64'(pending), 64'h1);
        chk("late_armed", 64'(armed), 64'h0);
`else
        chk("late_pend", 64'(pending), 64'h0);
        chk("late_armed", 64'(armed), 64'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
